// File: rtl/traffic_light_monitor.sv
// Observer for a red/yellow/green lamp interface: decodes the lamps to a phase,
// checks the RED->GREEN->YELLOW->RED order and dwell limits, and keeps error/cycle status.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 4,
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             go,
  output logic             lamp_err,
  output logic             seq_err,
  output logic             dwell_err,
  output logic             cycle_done,
  output logic             any_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] PH_RED    = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_NONE   = 2'b11;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] ONE_D = DWELL_W'(1);

  logic [0:0]         state, state_n;
  logic [1:0]         phase_n, sample;
  logic [DWELL_W-1:0] dwell, dwell_n;
  logic               valid, legal;
  logic               lamp_n, seq_n, dwell_err_n, done_n, err_n;

  always_comb begin
    valid  = 1'b1;
    sample = PH_NONE;
    unique case ({red, yellow, green})
      3'b100:  sample = PH_RED;
      3'b010:  sample = PH_YELLOW;
      3'b001:  sample = PH_GREEN;
      default: valid  = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    dwell_n     = dwell;
    legal       = 1'b0;
    lamp_n      = 1'b0;
    seq_n       = 1'b0;
    dwell_err_n = 1'b0;
    done_n      = 1'b0;
    if (!valid) begin
      // Phase and dwell are frozen; the next valid sample resyncs from INIT.
      lamp_n  = 1'b1;
      state_n = ST_INIT;
    end else if (state == ST_INIT) begin
      phase_n = sample;
      dwell_n = ONE_D;
      state_n = ST_TRACK;
    end else if (sample == phase) begin
      if (dwell != '1) dwell_n = dwell + ONE_D;
      dwell_err_n = (dwell == MAX_D);
    end else begin
      legal = (phase == PH_RED    && sample == PH_GREEN)  ||
              (phase == PH_GREEN  && sample == PH_YELLOW) ||
              (phase == PH_YELLOW && sample == PH_RED);
      seq_n       = !legal;
      dwell_err_n = (dwell < MIN_D);
      done_n      = legal && (phase == PH_YELLOW) && (dwell >= MIN_D) && (dwell <= MAX_D);
      phase_n     = sample;
      dwell_n     = ONE_D;
    end
    err_n = lamp_n | seq_n | dwell_err_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      phase       <= PH_NONE;
      dwell       <= '0;
      go          <= 1'b0;
      lamp_err    <= 1'b0;
      seq_err     <= 1'b0;
      dwell_err   <= 1'b0;
      cycle_done  <= 1'b0;
      any_err     <= 1'b0;
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      dwell      <= dwell_n;
      go         <= valid && (sample == PH_GREEN);
      lamp_err   <= lamp_n;
      seq_err    <= seq_n;
      dwell_err  <= dwell_err_n;
      cycle_done <= done_n;
      if (clear) begin
        // Events coinciding with clear are counted into the freshly cleared status.
        any_err     <= err_n;
        err_count   <= CNT_W'(err_n);
        cycle_count <= CNT_W'(done_n);
      end else begin
        any_err <= any_err | err_n;
        if (err_n && err_count != '1) err_count <= err_count + CNT_W'(1);
        if (done_n && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule
